// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe
//   Decode-stage control unit with registered ID/EX, EX/MEM and MEM/WB
//   control stages. The 6-bit opcode decodes into WB/MEM/EX control groups.
//   Stalls, flushes and idle slots insert bubbles. Illegal opcodes raise a
//   one-cycle pulse and bump a saturating counter.
// Parameters
//   EXT_OPS   : 1 = ADDI/ANDI legal, 0 = both illegal
//   ILL_CNT_W : illegal-opcode counter width
// Ports
//   clk, rst            : clock, async active-low reset
//   opcode, valid_in    : instruction[31:26] from IF/ID and its valid bit
//   stall, flush        : load-use bubble / branch-taken clear
//   idex_wb/mem/ex      : ID/EX control groups
//   exmem_wb/mem        : EX/MEM control groups
//   memwb_wb            : MEM/WB control group
//   illegal, ill_cnt    : illegal-opcode pulse and saturating count
module decode_ctrl_pipe #(
  parameter bit EXT_OPS   = 1'b1,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic                 valid_in,
  input  logic                 stall,
  input  logic                 flush,
  output logic [1:0]           idex_wb,
  output logic [2:0]           idex_mem,
  output logic [3:0]           idex_ex,
  output logic [1:0]           exmem_wb,
  output logic [2:0]           exmem_mem,
  output logic [1:0]           memwb_wb,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_cnt
);

  typedef struct packed {
    logic [1:0] wb;   // {RegWrite, MemtoReg}
    logic [2:0] mem;  // {Branch, MemRead, MemWrite}
    logic [3:0] ex;   // {RegDst, ALUOp[1:0], ALUSrc}
  } ctrl_t;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] mem;
  } wbmem_t;

  ctrl_t                dec;
  logic                 legal;
  ctrl_t                idex_d,    idex_q;
  wbmem_t               exmem_d,   exmem_q;
  logic [1:0]           memwb_d,   memwb_q;
  logic                 ill_d,     ill_q;
  logic [ILL_CNT_W-1:0] ill_cnt_d, ill_cnt_q;

  // Opcode decode; anything unlisted stays all-zero, which is a bubble.
  always_comb begin
    dec   = '0;
    legal = 1'b1;
    unique case (opcode)
      6'b000000: dec = '{wb: 2'b10, mem: 3'b000, ex: 4'b1100}; // RTYPE
      6'b100011: dec = '{wb: 2'b11, mem: 3'b010, ex: 4'b0001}; // LW
      6'b101011: dec = '{wb: 2'b00, mem: 3'b001, ex: 4'b0001}; // SW
      6'b000100: dec = '{wb: 2'b00, mem: 3'b100, ex: 4'b0010}; // BEQ
      6'b100000: dec = '0;                                      // NOP
      6'b001000: begin                                          // ADDI
        if (EXT_OPS) dec = '{wb: 2'b10, mem: 3'b000, ex: 4'b0001};
        else         legal = 1'b0;
      end
      6'b001100: begin                                          // ANDI
        if (EXT_OPS) dec = '{wb: 2'b10, mem: 3'b000, ex: 4'b0111};
        else         legal = 1'b0;
      end
      default:   legal = 1'b0;
    endcase
  end

  // Flush outranks stall; both outrank the decoded value.
  always_comb begin
    idex_d    = (flush || stall || !valid_in) ? ctrl_t'('0) : dec;
    exmem_d   = flush ? wbmem_t'('0) : '{wb: idex_q.wb, mem: idex_q.mem};
    memwb_d   = exmem_q.wb;
    ill_d     = valid_in && !legal && !stall && !flush;
    ill_cnt_d = ill_cnt_q;
    // Count on the same edge that raises the pulse, so both appear together.
    if (ill_d && (ill_cnt_q != {ILL_CNT_W{1'b1}}))
      ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_q    <= '0;
      exmem_q   <= '0;
      memwb_q   <= '0;
      ill_q     <= 1'b0;
      ill_cnt_q <= '0;
    end else begin
      idex_q    <= idex_d;
      exmem_q   <= exmem_d;
      memwb_q   <= memwb_d;
      ill_q     <= ill_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign idex_wb   = idex_q.wb;
  assign idex_mem  = idex_q.mem;
  assign idex_ex   = idex_q.ex;
  assign exmem_wb  = exmem_q.wb;
  assign exmem_mem = exmem_q.mem;
  assign memwb_wb  = memwb_q;
  assign illegal   = ill_q;
  assign ill_cnt   = ill_cnt_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
module tb_decode_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       valid_in, stall, flush;

  // EXT_OPS=1 / 8-bit counter instance
  logic [1:0] idex_wb, exmem_wb, memwb_wb;
  logic [2:0] idex_mem, exmem_mem;
  logic [3:0] idex_ex;
  logic       illegal;
  logic [7:0] ill_cnt;

  // EXT_OPS=0 / 2-bit counter instance, same stimulus
  logic [1:0] idex_wb0, exmem_wb0, memwb_wb0;
  logic [2:0] idex_mem0, exmem_mem0;
  logic [3:0] idex_ex0;
  logic       illegal0;
  logic [1:0] ill_cnt0;

  always #5 clk = ~clk;

  decode_ctrl_pipe #(.EXT_OPS(1'b1), .ILL_CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .valid_in(valid_in),
    .stall(stall), .flush(flush),
    .idex_wb(idex_wb), .idex_mem(idex_mem), .idex_ex(idex_ex),
    .exmem_wb(exmem_wb), .exmem_mem(exmem_mem), .memwb_wb(memwb_wb),
    .illegal(illegal), .ill_cnt(ill_cnt)
  );

  decode_ctrl_pipe #(.EXT_OPS(1'b0), .ILL_CNT_W(2)) u_dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .valid_in(valid_in),
    .stall(stall), .flush(flush),
    .idex_wb(idex_wb0), .idex_mem(idex_mem0), .idex_ex(idex_ex0),
    .exmem_wb(exmem_wb0), .exmem_mem(exmem_mem0), .memwb_wb(memwb_wb0),
    .illegal(illegal0), .ill_cnt(ill_cnt0)
  );

  localparam logic [8:0] C_R  = 9'b10_000_1100;
  localparam logic [8:0] C_LW = 9'b11_010_0001;
  localparam logic [8:0] C_SW = 9'b00_001_0001;
  localparam logic [8:0] C_BQ = 9'b00_100_0010;
  localparam logic [8:0] C_AD = 9'b10_000_0001;
  localparam logic [8:0] C_AN = 9'b10_000_0111;
  localparam logic [4:0] E_R  = 5'b10_000;
  localparam logic [4:0] E_LW = 5'b11_010;
  localparam logic [4:0] E_SW = 5'b00_001;
  localparam logic [4:0] E_BQ = 5'b00_100;

  localparam logic [5:0] OP_R  = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BQ = 6'b000100, OP_NP = 6'b100000, OP_AD = 6'b001000,
                         OP_AN = 6'b001100, OP_X1 = 6'b111100, OP_X2 = 6'b111111;

  typedef struct {
    logic [5:0] op;
    logic       v, st, fl;
    logic [8:0] idex;
    logic [4:0] exmem;
    logic [1:0] mw;
    logic       ill;
    logic [7:0] cnt;
    logic [8:0] idex0;
    logic       ill0;
    logic [1:0] cnt0;
  } vec_t;

  vec_t tbl[24];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".idex"},  {idex_wb, idex_mem, idex_ex}, 32'd0);
    chk({tag, ".exmem"}, {exmem_wb, exmem_mem}, 32'd0);
    chk({tag, ".memwb"}, memwb_wb, 32'd0);
    chk({tag, ".ill"},   illegal, 32'd0);
    chk({tag, ".cnt"},   ill_cnt, 32'd0);
    chk({tag, ".idex0"}, {idex_wb0, idex_mem0, idex_ex0}, 32'd0);
    chk({tag, ".cnt0"},  ill_cnt0, 32'd0);
    chk({tag, ".ill0"},  illegal0, 32'd0);
  endtask

  task automatic drive(input logic [5:0] op, input logic v, input logic st, input logic fl);
    opcode = op; valid_in = v; stall = st; flush = fl;
  endtask

  initial begin
    //          op     v  st fl  idex  exmem mw     ill cnt idex0 ill0 cnt0
    // reset-then-sequence
    tbl[0]  = '{OP_R,  1, 0, 0, C_R,  5'd0, 2'b00, 0, 0, C_R,  0, 0};
    tbl[1]  = '{OP_LW, 1, 0, 0, C_LW, E_R,  2'b00, 0, 0, C_LW, 0, 0};
    tbl[2]  = '{OP_SW, 1, 0, 0, C_SW, E_LW, 2'b10, 0, 0, C_SW, 0, 0};
    tbl[3]  = '{OP_BQ, 1, 0, 0, C_BQ, E_SW, 2'b11, 0, 0, C_BQ, 0, 0};
    tbl[4]  = '{OP_NP, 1, 0, 0, 9'd0, E_BQ, 2'b00, 0, 0, 9'd0, 0, 0};
    tbl[5]  = '{OP_X1, 1, 0, 0, 9'd0, 5'd0, 2'b00, 1, 1, 9'd0, 1, 1};
    tbl[6]  = '{OP_X2, 0, 0, 0, 9'd0, 5'd0, 2'b00, 0, 1, 9'd0, 0, 1};
    // two-cycle stall with RTYPE waiting
    tbl[7]  = '{OP_LW, 1, 0, 0, C_LW, 5'd0, 2'b00, 0, 1, C_LW, 0, 1};
    tbl[8]  = '{OP_R,  1, 1, 0, 9'd0, E_LW, 2'b00, 0, 1, 9'd0, 0, 1};
    tbl[9]  = '{OP_R,  1, 1, 0, 9'd0, 5'd0, 2'b11, 0, 1, 9'd0, 0, 1};
    tbl[10] = '{OP_R,  1, 0, 0, C_R,  5'd0, 2'b00, 0, 1, C_R,  0, 1};
    tbl[11] = '{OP_R,  0, 0, 0, 9'd0, E_R,  2'b00, 0, 1, 9'd0, 0, 1};
    tbl[12] = '{OP_R,  0, 0, 0, 9'd0, 5'd0, 2'b10, 0, 1, 9'd0, 0, 1};
    // flush with LW in EX/MEM, BEQ in ID/EX, LW in IF/ID
    tbl[13] = '{OP_LW, 1, 0, 0, C_LW, 5'd0, 2'b00, 0, 1, C_LW, 0, 1};
    tbl[14] = '{OP_BQ, 1, 0, 0, C_BQ, E_LW, 2'b00, 0, 1, C_BQ, 0, 1};
    tbl[15] = '{OP_LW, 1, 0, 1, 9'd0, 5'd0, 2'b11, 0, 1, 9'd0, 0, 1};
    // illegal suppressed by flush+stall, then by stall alone
    tbl[16] = '{OP_X2, 1, 1, 1, 9'd0, 5'd0, 2'b00, 0, 1, 9'd0, 0, 1};
    tbl[17] = '{OP_X2, 1, 1, 0, 9'd0, 5'd0, 2'b00, 0, 1, 9'd0, 0, 1};
    // ADDI/ANDI: legal on u_dut, illegal on u_dut0
    tbl[18] = '{OP_AD, 1, 0, 0, C_AD, 5'd0, 2'b00, 0, 1, 9'd0, 1, 2};
    tbl[19] = '{OP_AN, 1, 0, 0, C_AN, E_R,  2'b00, 0, 1, 9'd0, 1, 3};
    tbl[20] = '{OP_R,  0, 0, 0, 9'd0, E_R,  2'b10, 0, 1, 9'd0, 0, 3};
    tbl[21] = '{OP_R,  0, 0, 0, 9'd0, 5'd0, 2'b10, 0, 1, 9'd0, 0, 3};
    // u_dut0 already saturated: pulse still fires, count holds
    tbl[22] = '{OP_X2, 1, 0, 0, 9'd0, 5'd0, 2'b00, 1, 2, 9'd0, 1, 3};
    tbl[23] = '{OP_X2, 0, 0, 0, 9'd0, 5'd0, 2'b00, 0, 2, 9'd0, 0, 3};

    rst = 1'b0;
    drive(OP_R, 1'b0, 1'b0, 1'b0);
    #1;
    chk_all_zero("reset");
    #5 rst = 1'b1;  // t=6, first active edge at t=15

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].op, tbl[i].v, tbl[i].st, tbl[i].fl);
      @(posedge clk); #1;
      chk($sformatf("v%0d.idex", i),  {idex_wb, idex_mem, idex_ex}, tbl[i].idex);
      chk($sformatf("v%0d.exmem", i), {exmem_wb, exmem_mem}, tbl[i].exmem);
      chk($sformatf("v%0d.memwb", i), memwb_wb, tbl[i].mw);
      chk($sformatf("v%0d.ill", i),   illegal, tbl[i].ill);
      chk($sformatf("v%0d.cnt", i),   ill_cnt, tbl[i].cnt);
      chk($sformatf("v%0d.idex0", i), {idex_wb0, idex_mem0, idex_ex0}, tbl[i].idex0);
      chk($sformatf("v%0d.ill0", i),  illegal0, tbl[i].ill0);
      chk($sformatf("v%0d.cnt0", i),  ill_cnt0, tbl[i].cnt0);
    end

    // Async reset mid-stream, asserted between edges
    drive(OP_LW, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(OP_SW, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst.idex",  {idex_wb, idex_mem, idex_ex}, C_SW);
    chk("pre_rst.exmem", {exmem_wb, exmem_mem}, E_LW);
    #3 rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    chk_all_zero("rst_hold");
    #2 rst = 1'b1;
    drive(OP_LW, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("rel.idex",  {idex_wb, idex_mem, idex_ex}, C_LW);
    chk("rel.exmem", {exmem_wb, exmem_mem}, 32'd0);
    chk("rel.cnt",   ill_cnt, 32'd0);

    // Five illegal opcodes: 2-bit counter saturates at 3
    for (int k = 1; k <= 5; k++) begin
      drive(OP_X1, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("sat%0d.ill0", k), illegal0, 32'd1);
      chk($sformatf("sat%0d.cnt0", k), ill_cnt0, (k > 3) ? 32'd3 : k);
      chk($sformatf("sat%0d.ill", k),  illegal, 32'd1);
      chk($sformatf("sat%0d.cnt", k),  ill_cnt, k);
    end
    drive(OP_X1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("sat_end.ill0", illegal0, 32'd0);
    chk("sat_end.cnt0", ill_cnt0, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
